// File: rtl/scnn_pkg.sv
// Shared types and helpers for the SCNN tile controller.
// State encoding, activation width and index-width helper.
package scnn_pkg;

    localparam int ACT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        COMPUTE,
        REDUCE,
        DONE
    } ctrl_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scnn_reduce_unit.sv
// Output tile accumulator: IP_SIZE parallel wrapping adders.
// Cleared on tile accept, accumulates one PE buffer per enabled cycle.
module scnn_reduce_unit #(
    parameter int IP_SIZE = 16,
    parameter int OUT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic [IP_SIZE*OUT_W-1:0] add_in,
    output logic [IP_SIZE*OUT_W-1:0] sum
);

    logic [IP_SIZE*OUT_W-1:0] sum_q;
    logic [IP_SIZE*OUT_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            for (int k = 0; k < IP_SIZE; k++) begin
                sum_d[k*OUT_W +: OUT_W] = sum_q[k*OUT_W +: OUT_W]
                                        + add_in[k*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/scnn_controller_npe.sv
// SCNN tile controller for NUM_PE external PEs: latch, launch,
// wait for all PEs, reduce their buffers, present on valid/ready.
module scnn_controller_npe
    import scnn_pkg::*;
#(
    parameter int NUM_PE  = 4,
    parameter int IP_SIZE = 16,
    parameter int WT_SIZE = 25,
    parameter int OUT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    input  logic [IP_SIZE*ACT_W-1:0]        input_acts,
    input  logic [7:0]                      input_dim,
    input  logic [WT_SIZE*ACT_W-1:0]        weights,
    input  logic [3:0]                      weight_dim,
    output logic                            pe_start,
    output logic [IP_SIZE*ACT_W-1:0]        pe_ips,
    output logic [WT_SIZE*ACT_W-1:0]        pe_wts,
    output logic [7:0]                      pe_ip_dim,
    output logic [3:0]                      pe_wt_dim,
    input  logic [NUM_PE-1:0]               pe_done,
    input  logic [NUM_PE*IP_SIZE*OUT_W-1:0] pe_acc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [IP_SIZE*OUT_W-1:0]        outputs,
    output logic                            err_timeout
);

    localparam int IDX_W = clog2_min1(NUM_PE);
    localparam int CNT_W = clog2_min1(TIMEOUT + 1);
    localparam int BUF_W = IP_SIZE * OUT_W;

    ctrl_state_t state_q, state_d;

    logic [IP_SIZE*ACT_W-1:0] ips_q, ips_d;
    logic [WT_SIZE*ACT_W-1:0] wts_q, wts_d;
    logic [7:0]               ip_dim_q, ip_dim_d;
    logic [3:0]               wt_dim_q, wt_dim_d;
    logic [NUM_PE-1:0]        done_seen_q, done_seen_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;

    logic             accept;
    logic             all_done;
    logic             timed_out;
    logic             last_pe;
    logic             red_clr;
    logic             red_en;
    logic [BUF_W-1:0] acc_sel;

    assign accept    = (state_q == IDLE) && start;
    // A PE finishing in this very cycle counts, so REDUCE follows at once.
    assign all_done  = &(done_seen_q | pe_done);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    assign last_pe   = (idx_q == IDX_W'(NUM_PE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LAUNCH;
            LAUNCH:  state_d = COMPUTE;
            COMPUTE: begin
                if (all_done)       state_d = REDUCE;
                else if (timed_out) state_d = DONE;
            end
            REDUCE:  if (last_pe) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        pe_start  = (state_q == LAUNCH);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        ips_d       = ips_q;
        wts_d       = wts_q;
        ip_dim_d    = ip_dim_q;
        wt_dim_d    = wt_dim_q;
        done_seen_d = done_seen_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        if (accept) begin
            ips_d       = input_acts;
            wts_d       = weights;
            ip_dim_d    = input_dim;
            wt_dim_d    = weight_dim;
            done_seen_d = '0;
            idx_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
        end
        if (state_q == COMPUTE) begin
            done_seen_d = done_seen_q | pe_done;
            cnt_d       = cnt_q + CNT_W'(1);
            if (timed_out && !all_done) err_d = 1'b1;
        end
        if (state_q == REDUCE) idx_d = idx_q + IDX_W'(1);
    end

    always_comb begin
        acc_sel = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            if (idx_q == IDX_W'(p)) acc_sel = pe_acc[p*BUF_W +: BUF_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ips_q       <= '0;
            wts_q       <= '0;
            ip_dim_q    <= '0;
            wt_dim_q    <= '0;
            done_seen_q <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            ips_q       <= ips_d;
            wts_q       <= wts_d;
            ip_dim_q    <= ip_dim_d;
            wt_dim_q    <= wt_dim_d;
            done_seen_q <= done_seen_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign red_clr = accept;
    assign red_en  = (state_q == REDUCE);

    scnn_reduce_unit #(
        .IP_SIZE (IP_SIZE),
        .OUT_W   (OUT_W)
    ) u_reduce (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (red_clr),
        .en      (red_en),
        .add_in  (acc_sel),
        .sum     (outputs)
    );

    assign pe_ips      = ips_q;
    assign pe_wts      = wts_q;
    assign pe_ip_dim   = ip_dim_q;
    assign pe_wt_dim   = wt_dim_q;
    assign err_timeout = err_q;

endmodule
